work_frame_loader: RTL and testbench

- Sits directly downstream of the serial RX path. It consumes the per-byte receive strobe and the 256-bit midstate/data2 views of the serial shift buffer.
- Counts bytes into 64-byte work frames and resynchronises framing after an inter-byte gap timeout.
- On frame completion, snapshots midstate/data2 into stable registers and pulses new_work to the hasher pipeline.
- Prevents the hashers from seeing a partially shifted buffer.

---
 rtl/work_frame_loader_pkg.sv | 15 +
 rtl/work_frame_loader_gap_timer.sv | 27 ++
 rtl/work_frame_loader.sv | 105 ++++++++++
 tb/tb_work_frame_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/work_frame_loader_pkg.sv
// Shared constants and state encoding for the work frame loader.
package work_frame_loader_pkg;

    localparam int unsigned FRAME_BYTES_DEF = 64;
    localparam int unsigned MIDSTATE_W      = 256;
    localparam int unsigned DATA2_W         = 256;
    localparam int unsigned BITS_PER_BYTE   = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        CAPTURE = 2'd2
    } state_e;

endpackage

// File: rtl/work_frame_loader_gap_timer.sv
// Idle-gap counter: cleared by each byte strobe, pulses expired_c on the last idle tick.
module gap_timer #(
    parameter int unsigned TICKS = 400
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TICKS + 1);

    logic [CNT_W-1:0] count;

    // A strobe on the terminal tick wins, so it masks the expiry.
    assign expired_c = run && !clear && (count == CNT_W'(TICKS - 1));

    always_ff @(posedge clk) begin
        if (reset || clear || !run || expired_c) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/work_frame_loader.sv
// Frames serial RX bytes into 64-byte work units and snapshots midstate/data2 for the hashers.
// Optional gap timeout that discards stalled partial frames: define FRAME_TIMEOUT_EN.
module work_frame_loader
    import work_frame_loader_pkg::*;
#(
    parameter int unsigned CLOCK         = 100_000_000,
    parameter int unsigned BAUD          = 115_200,
    parameter int unsigned FRAME_BYTES   = FRAME_BYTES_DEF,
    parameter int unsigned TIMEOUT_BYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_ready,
    input  logic [MIDSTATE_W-1:0] midstate_in,
    input  logic [DATA2_W-1:0]    data2_in,
    output logic [MIDSTATE_W-1:0] midstate,
    output logic [DATA2_W-1:0]    data2,
    output logic                  new_work,
    output logic                  loading,
    output logic                  frame_dropped
);

    localparam int unsigned BIT_TICKS     = CLOCK / BAUD;
    localparam int unsigned TIMEOUT_TICKS = TIMEOUT_BYTES * BITS_PER_BYTE * BIT_TICKS;
    localparam int unsigned CNT_W         = $clog2(FRAME_BYTES + 1);

    state_e           state;
    logic [CNT_W-1:0] byte_cnt;
    logic             timer_expired_c;

`ifdef FRAME_TIMEOUT_EN
    gap_timer #(
        .TICKS(TIMEOUT_TICKS)
    ) u_gap_timer (
        .clk      (clk),
        .reset    (reset),
        .run      (state == RECV),
        .clear    (rx_ready),
        .expired_c(timer_expired_c)
    );
`else
    // No gap timer: partial frames persist until completion or reset.
    assign timer_expired_c = 1'b0 & (TIMEOUT_TICKS != 0);
`endif

    // Byte framing FSM; loading tracks the next byte count so it drops with new_work.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            byte_cnt      <= '0;
            midstate      <= '0;
            data2         <= '0;
            new_work      <= 1'b0;
            loading       <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            new_work      <= 1'b0;
            frame_dropped <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        byte_cnt <= CNT_W'(1);
                        loading  <= 1'b1;
                        state    <= RECV;
                    end
                end
                RECV: begin
                    if (rx_ready) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        loading  <= 1'b1;
                        if (byte_cnt == CNT_W'(FRAME_BYTES - 1)) begin
                            state <= CAPTURE;
                        end
                    end else if (timer_expired_c) begin
                        byte_cnt      <= '0;
                        loading       <= 1'b0;
                        frame_dropped <= 1'b1;
                        state         <= IDLE;
                    end
                end
                CAPTURE: begin
                    midstate <= midstate_in;
                    data2    <= data2_in;
                    new_work <= 1'b1;
                    // A byte landing on the capture cycle opens the next frame.
                    if (rx_ready) begin
                        byte_cnt <= CNT_W'(1);
                        loading  <= 1'b1;
                        state    <= RECV;
                    end else begin
                        byte_cnt <= '0;
                        loading  <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    byte_cnt <= '0;
                    loading  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_work_frame_loader.sv
// Directed bench for work_frame_loader with a capture scoreboard; follows FRAME_TIMEOUT_EN.
module tb_work_frame_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         rx_ready = 1'b0;
    logic [255:0] midstate_in = '0;
    logic [255:0] data2_in = '0;
    logic [255:0] midstate;
    logic [255:0] data2;
    logic         new_work;
    logic         loading;
    logic         frame_dropped;

    int n_assert = 0;
    int n_fail   = 0;
    int nw_seen  = 0;
    int drop_seen = 0;

    logic [511:0] exp_q[$];
    logic [255:0] model_ms = '0;
    logic [255:0] model_d2 = '0;

    work_frame_loader #(
        .CLOCK        (1000),
        .BAUD         (100),
        .FRAME_BYTES  (64),
        .TIMEOUT_BYTES(4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_ready     (rx_ready),
        .midstate_in  (midstate_in),
        .data2_in     (data2_in),
        .midstate     (midstate),
        .data2        (data2),
        .new_work     (new_work),
        .loading      (loading),
        .frame_dropped(frame_dropped)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    task automatic check256(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Scoreboard side: every new_work pulse must match the oldest queued frame.
    always @(negedge clk) begin
        logic [511:0] e;
        if (new_work) begin
            nw_seen++;
            if (exp_q.size() == 0) begin
                check1("unexpected_new_work", new_work, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check256("sb_midstate", midstate, e[511:256]);
                check256("sb_data2", data2, e[255:0]);
            end
        end
        if (frame_dropped) drop_seen++;
        if (new_work || frame_dropped) check1("pulse_exclusive", new_work & frame_dropped, 1'b0);
    end

    // n bytes with fresh junk in the buffer, each preceded by 'idle' quiet cycles; ends on the negedge after the sampling edge.
    task automatic send_random(input int n, input int idle);
        for (int i = 0; i < n; i++) begin
            repeat (idle) @(negedge clk);
            @(negedge clk);
            midstate_in = rand256();
            data2_in    = rand256();
            rx_ready    = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
    endtask

    // Last byte of a frame with the given buffer contents, then latency/hold checks.
    task automatic send_final(input logic [255:0] ms, input logic [255:0] d2);
        exp_q.push_back({ms, d2});
        @(negedge clk);
        midstate_in = ms;
        data2_in    = d2;
        rx_ready    = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check1("capture_no_early_pulse", new_work, 1'b0);
        check1("capture_loading", loading, 1'b1);
        check256("capture_old_midstate", midstate, model_ms);
        @(negedge clk);
        midstate_in = rand256();
        data2_in    = rand256();
        check1("new_work_latency", new_work, 1'b1);
        check1("loading_falls", loading, 1'b0);
        check256("out_midstate", midstate, ms);
        check256("out_data2", data2, d2);
        model_ms = ms;
        model_d2 = d2;
        @(negedge clk);
        check1("single_pulse", new_work, 1'b0);
        check256("hold_midstate", midstate, ms);
    endtask

    initial begin
        logic [255:0] ms;
        logic [255:0] d2;
        int exp_nw;
        int exp_drop;
        exp_nw = 0;
        exp_drop = 0;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check256("rst_midstate", midstate, '0);
        check256("rst_data2", data2, '0);
        check1("rst_new_work", new_work, 1'b0);
        check1("rst_loading", loading, 1'b0);
        check1("rst_frame_dropped", frame_dropped, 1'b0);
        reset = 1'b0;

        // Frame A: 64 bytes spaced 100 cycles, A5/5A pattern at the last byte
        send_random(1, 98);
        check1("loading_after_byte1", loading, 1'b1);
        send_random(62, 98);
        repeat (98) @(negedge clk);
        send_final({8{32'h0000_00A5}}, {8{32'h0000_005A}});
        exp_nw++;

`ifdef FRAME_TIMEOUT_EN
        // Partial frame times out after 400 idle cycles
        send_random(10, 1);
        repeat (399) @(negedge clk);
        check1("drop_not_early", frame_dropped, 1'b0);
        check1("loading_before_drop", loading, 1'b1);
        @(negedge clk);
        check1("drop_pulse", frame_dropped, 1'b1);
        check1("loading_after_drop", loading, 1'b0);
        check256("drop_midstate_hold", midstate, model_ms);
        check256("drop_data2_hold", data2, model_d2);
        @(negedge clk);
        check1("drop_single", frame_dropped, 1'b0);
        exp_drop++;
        send_random(63, 1);
        send_final(rand256(), rand256());
        exp_nw++;

        // Strobe on the terminal idle tick wins over the timeout
        send_random(10, 1);
        send_random(1, 398);
        check1("edge_no_drop", frame_dropped, 1'b0);
        check1("edge_loading", loading, 1'b1);
        send_random(52, 1);
        send_final(rand256(), rand256());
        exp_nw++;
`else
        // Without the timeout a long gap leaves the partial frame intact
        send_random(10, 1);
        repeat (10000) @(negedge clk);
        check1("gap_loading_kept", loading, 1'b1);
        check1("gap_no_drop", frame_dropped, 1'b0);
        send_random(53, 1);
        send_final(rand256(), rand256());
        exp_nw++;
`endif

        // Byte 65 lands on the capture cycle and opens frame 2
        send_random(63, 1);
        ms = rand256();
        d2 = rand256();
        exp_q.push_back({ms, d2});
        @(negedge clk);
        midstate_in = ms;
        data2_in    = d2;
        rx_ready    = 1'b1;
        @(negedge clk);
        check1("b65_no_early_pulse", new_work, 1'b0);
        @(negedge clk);
        rx_ready = 1'b0;
        check1("b65_new_work", new_work, 1'b1);
        check1("b65_loading", loading, 1'b1);
        check256("b65_midstate", midstate, ms);
        check256("b65_data2", data2, d2);
        model_ms = ms;
        model_d2 = d2;
        exp_nw++;
        send_random(62, 1);
        send_final(rand256(), rand256());
        exp_nw++;

        // Reset mid-frame discards the partial frame and clears outputs
        send_random(30, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check256("midrst_midstate", midstate, '0);
        check256("midrst_data2", data2, '0);
        check1("midrst_loading", loading, 1'b0);
        check1("midrst_new_work", new_work, 1'b0);
        check1("midrst_dropped", frame_dropped, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        model_ms = '0;
        model_d2 = '0;
        send_random(63, 1);
        send_final(rand256(), rand256());
        exp_nw++;

        repeat (5) @(negedge clk);
        check_int("sb_drained", exp_q.size(), 0);
        check_int("new_work_count", nw_seen, exp_nw);
        check_int("drop_count", drop_seen, exp_drop);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
